// File: rtl/param_fake_pkg.sv
// rtl/param_fake_pkg.sv - shared types and constants for the parameter-fake monitor
package param_fake_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_REPORT,
    ST_DONE
  } state_e;

  localparam int         FRAME_W = 16;
  localparam logic [1:0] MARKER  = 2'b10;
  localparam int         MASK_W  = 6;

  localparam int M_BOO = 0;
  localparam int M_INT = 1;
  localparam int M_LOG = 2;
  localparam int M_VEC = 3;
  localparam int M_STR = 4;
  localparam int M_REA = 5;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/param_frame_ser.sv
// rtl/param_frame_ser.sv - parallel-in serial-out frame shifter, LSB first
module param_frame_ser
  import param_fake_pkg::*;
#(
  parameter int W = FRAME_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  output logic         ser_o,
  output logic         valid_o,
  output logic         last_o
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load_i) begin
      shreg_d = data_i;
      cnt_d   = CW'(W - 1);
      valid_d = 1'b1;
    end else if (valid_q) begin
      shreg_d = shreg_q >> 1;
      if (cnt_q == '0) valid_d = 1'b0;
      else             cnt_d   = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign ser_o   = valid_q & shreg_q[0];
  assign valid_o = valid_q;
  assign last_o  = valid_q && (cnt_q == '0);

endmodule

// File: rtl/param_monitor.sv
// rtl/param_monitor.sv - settle/sample/report checker for the parameter-fake outputs
module param_monitor
  import param_fake_pkg::*;
#(
  parameter bit         EXP_BOO = 1'b1,
  parameter int         EXP_INT = 92,
  parameter logic       EXP_LOG = 1'b1,
  parameter logic [7:0] EXP_VEC = 8'hCC,
  parameter int         SETTLE  = 4,
  parameter int         SAMPLES = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              boo_i,
  input  logic [7:0]        int_i,
  input  logic              log_i,
  input  logic [7:0]        vec_i,
  input  logic              str_i,
  input  logic              rea_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [MASK_W-1:0] mask_o,
  output logic              ser_o,
  output logic              ser_valid_o
);

  localparam int               CNT_W     = $clog2(max3(SETTLE, SAMPLES, FRAME_W)) + 1;
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] SAMPLE_LD = CNT_W'(SAMPLES - 1);
  localparam logic [7:0]       EXP_INT8  = 8'(EXP_INT);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MASK_W-1:0]   mask_q, mask_d, miss;
  logic [7:0]          vec_cap_q, vec_cap_d;
  logic                done_q, done_d;
  logic                ser_load, ser_last, ser_bit, ser_valid;

  always_comb begin
    miss        = '0;
    miss[M_BOO] = (boo_i != EXP_BOO);
    miss[M_INT] = (int_i != EXP_INT8);
    miss[M_LOG] = (log_i != EXP_LOG);
    miss[M_VEC] = (vec_i != EXP_VEC);
    miss[M_STR] = (str_i != 1'b1);
    miss[M_REA] = (rea_i != 1'b1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_i)       state_d = ST_SETTLE;
      ST_SETTLE: if (cnt_q == '0)   state_d = ST_SAMPLE;
      ST_SAMPLE: if (cnt_q == '0)   state_d = ST_REPORT;
      ST_REPORT: if (ser_last)      state_d = ST_DONE;
      ST_DONE:   if (start_i)       state_d = ST_SETTLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  // Counter reloads on every state change; the settle phase therefore spans
  // its entry cycle plus SETTLE countdown cycles.
  always_comb begin
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    vec_cap_d = vec_cap_q;
    done_d    = (state_q == ST_REPORT) && (state_d == ST_DONE);
    if (state_d != state_q) begin
      case (state_d)
        ST_SETTLE: cnt_d = SETTLE_LD;
        ST_SAMPLE: cnt_d = SAMPLE_LD;
        default:   cnt_d = '0;
      endcase
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (state_d == ST_SETTLE && state_q != ST_SETTLE) begin
      mask_d    = '0;
      vec_cap_d = '0;
    end
    if (state_q == ST_SAMPLE) begin
      mask_d = mask_q | miss;
      if (cnt_q == SAMPLE_LD) vec_cap_d = vec_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      mask_q    <= '0;
      vec_cap_q <= '0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      vec_cap_q <= vec_cap_d;
      done_q    <= done_d;
    end
  end

  // Frame is loaded from the next-state values so the last sample is included.
  assign ser_load = (state_q == ST_SAMPLE) && (state_d == ST_REPORT);

  param_frame_ser #(.W(FRAME_W)) u_ser (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (ser_load),
    .data_i  ({vec_cap_d, MARKER, mask_d}),
    .ser_o   (ser_bit),
    .valid_o (ser_valid),
    .last_o  (ser_last)
  );

  always_comb begin
    busy_o      = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE) || (state_q == ST_REPORT);
    done_o      = done_q;
    pass_o      = (state_q == ST_DONE) && (mask_q == '0);
    mask_o      = mask_q;
    ser_o       = ser_bit;
    ser_valid_o = ser_valid;
  end

endmodule

// File: tb/tb_param_monitor.sv
// tb/tb_param_monitor.sv - self-checking bench for param_monitor
module tb_param_monitor;

  localparam int SETTLE  = 4;
  localparam int SAMPLES = 8;
  localparam int FW      = 16;
  // record index n holds the cycle t+n-1, where t is the edge that sees start_i
  localparam int NV   = SETTLE + SAMPLES + 2;
  localparam int ND   = NV + FW;
  localparam int LMAX = 64;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic       boo = 1'b1, lg = 1'b1, str = 1'b1, rea = 1'b1;
  logic [7:0] iv = 8'd92, vv = 8'hCC;
  logic       busy, done, pass, ser, ser_valid;
  logic [5:0] mask;

  int total = 0;
  int bad   = 0;

  logic       p_start[LMAX], p_boo[LMAX], p_log[LMAX], p_str[LMAX], p_rea[LMAX];
  logic [7:0] p_int[LMAX], p_vec[LMAX];
  logic       r_busy[LMAX], r_done[LMAX], r_pass[LMAX], r_ser[LMAX], r_val[LMAX];
  logic [5:0] r_mask[LMAX];

  typedef struct {
    string      name;
    logic       b;
    logic [7:0] i;
    logic       l;
    logic [7:0] v;
    logic       s;
    logic       r;
    logic [5:0] em;
    logic [15:0] ef;
  } vec_t;

  vec_t tbl[8];

  param_monitor #(
    .EXP_BOO(1'b1), .EXP_INT(92), .EXP_LOG(1'b1), .EXP_VEC(8'hCC),
    .SETTLE(SETTLE), .SAMPLES(SAMPLES)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .boo_i(boo), .int_i(iv), .log_i(lg), .vec_i(vv), .str_i(str), .rea_i(rea),
    .busy_o(busy), .done_o(done), .pass_o(pass), .mask_o(mask),
    .ser_o(ser), .ser_valid_o(ser_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic cmp(input string what, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", what, act, exp);
    end
  endtask

  task automatic set_const(input logic b, input logic [7:0] i, input logic l,
                           input logic [7:0] v, input logic s, input logic r);
    for (int n = 0; n < LMAX; n++) begin
      p_start[n] = (n == 0);
      p_boo[n] = b; p_int[n] = i; p_log[n] = l;
      p_vec[n] = v; p_str[n] = s; p_rea[n] = r;
    end
  endtask

  task automatic run(input int len);
    for (int n = 0; n < len; n++) begin
      @(negedge clk);
      r_busy[n] = busy; r_done[n] = done; r_pass[n] = pass;
      r_ser[n]  = ser;  r_val[n]  = ser_valid; r_mask[n] = mask;
      start = p_start[n]; boo = p_boo[n]; iv = p_int[n]; lg = p_log[n];
      vv = p_vec[n]; str = p_str[n]; rea = p_rea[n];
    end
    start = 1'b0;
  endtask

  // Expected result straight from the rules: OR of mismatches over the SAMPLES
  // cycles preceding the first frame bit, vec taken from the first of them.
  task automatic model(output logic [5:0] m, output logic [15:0] f);
    m = '0;
    for (int n = NV - SAMPLES; n < NV; n++) begin
      if (p_boo[n] !== 1'b1)   m[0] = 1'b1;
      if (p_int[n] !== 8'd92)  m[1] = 1'b1;
      if (p_log[n] !== 1'b1)   m[2] = 1'b1;
      if (p_vec[n] !== 8'hCC)  m[3] = 1'b1;
      if (p_str[n] !== 1'b1)   m[4] = 1'b1;
      if (p_rea[n] !== 1'b1)   m[5] = 1'b1;
    end
    f = {p_vec[NV - SAMPLES], 2'b10, m};
  endtask

  task automatic check(input string name, input logic [5:0] em, input logic [15:0] ef,
                       input int dn, input int len);
    int nd;
    logic vok, bok;
    logic [15:0] fr;
    nd = 0; vok = 1'b1; bok = 1'b1; fr = '0;
    for (int n = 1; n < len; n++) begin
      if (r_done[n]) nd++;
      if (r_val[n] !== ((n >= dn - FW) && (n < dn))) vok = 1'b0;
    end
    for (int n = 1; n < dn; n++) if (r_busy[n] !== 1'b1) bok = 1'b0;
    for (int k = 0; k < FW; k++) fr[k] = r_ser[dn - FW + k];
    cmp({name, " done_at"}, 32'(r_done[dn]), 32'd1);
    cmp({name, " done_count"}, nd, 32'd1);
    cmp({name, " valid_window"}, 32'(vok), 32'd1);
    cmp({name, " busy"}, {31'd0, bok, r_busy[dn]} , 32'd2);
    cmp({name, " frame"}, 32'(fr), 32'(ef));
    cmp({name, " mask"}, 32'(r_mask[dn]), 32'(em));
    cmp({name, " pass"}, 32'(r_pass[dn]), 32'(em == 6'd0));
  endtask

  initial begin
    logic [5:0]  em;
    logic [15:0] ef;
    int          idle_bad;

    tbl[0] = '{"all_ok",  1'b1, 8'd92, 1'b1, 8'hCC, 1'b1, 1'b1, 6'b000000, 16'hCC80};
    tbl[1] = '{"int_91",  1'b1, 8'd91, 1'b1, 8'hCC, 1'b1, 1'b1, 6'b000010, 16'hCC82};
    tbl[2] = '{"boo_0",   1'b0, 8'd92, 1'b1, 8'hCC, 1'b1, 1'b1, 6'b000001, 16'hCC81};
    tbl[3] = '{"log_0",   1'b1, 8'd92, 1'b0, 8'hCC, 1'b1, 1'b1, 6'b000100, 16'hCC84};
    tbl[4] = '{"vec_33",  1'b1, 8'd92, 1'b1, 8'h33, 1'b1, 1'b1, 6'b001000, 16'h3388};
    tbl[5] = '{"str_0",   1'b1, 8'd92, 1'b1, 8'hCC, 1'b0, 1'b1, 6'b010000, 16'hCC90};
    tbl[6] = '{"rea_0",   1'b1, 8'd92, 1'b1, 8'hCC, 1'b1, 1'b0, 6'b100000, 16'hCCA0};
    tbl[7] = '{"all_bad", 1'b0, 8'd0,  1'b0, 8'h00, 1'b0, 1'b0, 6'b111111, 16'h00BF};

    #3;
    cmp("reset busy", 32'(busy), 32'd0);
    cmp("reset outs", {26'd0, done, pass, ser, ser_valid, mask[1:0]}, 32'd0);
    cmp("reset mask", 32'(mask), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    cmp("idle busy", 32'(busy), 32'd0);

    for (int e = 0; e < 8; e++) begin
      set_const(tbl[e].b, tbl[e].i, tbl[e].l, tbl[e].v, tbl[e].s, tbl[e].r);
      run(ND + 2);
      check(tbl[e].name, tbl[e].em, tbl[e].ef, ND, ND + 2);
    end

    set_const(1, 92, 1, 8'hCC, 1, 1);
    p_str[NV - SAMPLES + 3] = 1'b0;
    run(ND + 2);
    check("str_mid", 6'b010000, 16'hCC90, ND, ND + 2);

    set_const(1, 92, 1, 8'hCC, 1, 1);
    p_str[3] = 1'b0;
    run(ND + 2);
    check("str_settle", 6'b000000, 16'hCC80, ND, ND + 2);

    set_const(1, 92, 1, 8'hCC, 1, 1);
    p_str[NV - SAMPLES - 1] = 1'b0;
    run(ND + 2);
    check("str_pre_window", 6'b000000, 16'hCC80, ND, ND + 2);

    set_const(1, 92, 1, 8'hCC, 1, 1);
    p_str[NV - 1] = 1'b0;
    run(ND + 2);
    check("str_last_sample", 6'b010000, 16'hCC90, ND, ND + 2);

    set_const(1, 92, 1, 8'hCC, 1, 1);
    p_vec[NV - SAMPLES] = 8'h5A;
    run(ND + 2);
    check("vec_first_cap", 6'b001000, 16'h5A88, ND, ND + 2);

    set_const(1, 92, 1, 8'hCC, 1, 1);
    p_start[NV + 3] = 1'b1;
    run(ND + 6);
    check("start_in_report", 6'b000000, 16'hCC80, ND, ND + 6);

    set_const(1, 92, 1, 8'hCC, 1, 1);
    p_start[ND] = 1'b1;
    run(2 * ND + 2);
    cmp("restart done1", 32'(r_done[ND]), 32'd1);
    cmp("restart pass1", 32'(r_pass[ND]), 32'd1);
    cmp("restart busy", {30'd0, r_busy[ND + 1], r_pass[ND + 1]}, 32'd2);
    cmp("restart done2", 32'(r_done[2 * ND]), 32'd1);
    cmp("restart no_early", 32'(r_done[2 * ND - 1] | r_done[ND + 1]), 32'd0);

    @(negedge clk);
    start = 1'b1; iv = 8'd91;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    cmp("pre_rst busy", 32'(busy), 32'd1);
    cmp("pre_rst mask", 32'(mask), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    cmp("rst busy", 32'(busy), 32'd0);
    cmp("rst ser_valid", 32'(ser_valid), 32'd0);
    cmp("rst mask", 32'(mask), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; iv = 8'd92;
    idle_bad = 0;
    repeat (ND + 2) begin
      @(negedge clk);
      if (busy || ser_valid || done || pass) idle_bad++;
    end
    cmp("post_rst idle", idle_bad, 32'd0);

    for (int r = 0; r < 20; r++) begin
      for (int n = 0; n < LMAX; n++) begin
        p_start[n] = (n == 0) || (n >= 2 && n < ND && $urandom_range(0, 7) == 0);
        p_boo[n] = ($urandom_range(0, 15) != 0);
        p_int[n] = ($urandom_range(0, 15) != 0) ? 8'd92 : 8'($urandom);
        p_log[n] = ($urandom_range(0, 15) != 0);
        p_vec[n] = ($urandom_range(0, 3) != 0) ? 8'hCC : 8'($urandom);
        p_str[n] = ($urandom_range(0, 15) != 0);
        p_rea[n] = ($urandom_range(0, 15) != 0);
      end
      model(em, ef);
      run(ND + 2);
      check($sformatf("rand%0d", r), em, ef, ND, ND + 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
